// File: rtl/regfile_write_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_arb_pkg: shared defaults, state encoding and width helpers        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package regfile_arb_pkg;

  localparam int DEF_NUM_REQ  = 3;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_LOCK_MAX = 8;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  // A single requester still needs a 1-bit id
  function automatic int id_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_write_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_write_arbiter_if: requester handshake plus register-file write    |
// | port. Rev 1.0                                                             |
// +--------------------------------------------------------------------------+
interface regfile_write_arbiter_if
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) ();
  localparam int ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ*ADDR_W-1:0] req_reg;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [ADDR_W-1:0]         write_reg;
  logic [DATA_W-1:0]         write_data;
  logic                      reg_write;
  logic [ID_W-1:0]           grant_id;
  logic                      locked;

  modport master (
    output req_valid, req_lock, req_reg, req_data,
    input  req_ready, write_reg, write_data, reg_write, grant_id, locked
  );

  modport slave (
    input  req_valid, req_lock, req_reg, req_data,
    output req_ready, write_reg, write_data, reg_write, grant_id, locked
  );
endinterface
`default_nettype wire

// File: rtl/regfile_write_arbiter_picker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_priority_picker: combinational rotating-priority encoder               |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module rr_priority_picker
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    winner,
  output logic               any_valid
);

  always_comb begin
    int idx;
    grant     = '0;
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!any_valid && req[ID_W'(idx)]) begin
        any_valid          = 1'b1;
        winner             = ID_W'(idx);
        grant[ID_W'(idx)]  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_write_arbiter: round-robin arbiter with locked bursts for the     |
// | single register-file write port. Rev 1.0                                  |
// +--------------------------------------------------------------------------+
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int LOCK_MAX    = DEF_LOCK_MAX,
  parameter int ZERO_REG_RO = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  regfile_write_arbiter_if.slave  bus
);
  localparam int ID_W  = id_width(NUM_REQ);
  localparam int CNT_W = clog2(LOCK_MAX + 1);

  arb_state_t          state, state_nx;
  logic [ID_W-1:0]     rr_ptr, ptr_nx, owner, owner_nx;
  logic [ID_W-1:0]     pick_id, acc_id, gid;
  logic [CNT_W-1:0]    lock_cnt, cnt_nx;
  logic [NUM_REQ-1:0]  pick_grant, ready;
  logic                pick_any, accept, wen;
  logic [ADDR_W-1:0]   wreg;
  logic [DATA_W-1:0]   wdata;
  logic [ADDR_W-1:0]   reg_arr  [NUM_REQ];
  logic [DATA_W-1:0]   data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign reg_arr[i]  = bus.req_reg[i*ADDR_W +: ADDR_W];
    assign data_arr[i] = bus.req_data[i*DATA_W +: DATA_W];
  end

  rr_priority_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_picker (
    .req       (bus.req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (pick_grant),
    .winner    (pick_id),
    .any_valid (pick_any)
  );

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    ptr_nx   = rr_ptr;
    cnt_nx   = lock_cnt;
    ready    = '0;
    accept   = 1'b0;
    acc_id   = pick_id;
    case (state)
      LOCKED: begin
        acc_id = owner;
        if (bus.req_valid[owner]) begin
          ready[owner] = 1'b1;
          accept       = 1'b1;
          if (bus.req_lock[owner]) begin
            cnt_nx = '0;
          end else begin
            state_nx = ARB;
            ptr_nx   = ID_W'(rr_next(int'(owner), NUM_REQ));
          end
        end else if (lock_cnt == CNT_W'(LOCK_MAX - 1)) begin
          // Owner idle too long: release so the others cannot starve
          state_nx = ARB;
          ptr_nx   = ID_W'(rr_next(int'(owner), NUM_REQ));
          cnt_nx   = '0;
        end else begin
          cnt_nx = lock_cnt + 1'b1;
        end
      end
      default: begin
        ready = pick_grant;
        if (pick_any) begin
          accept = 1'b1;
          ptr_nx = ID_W'(rr_next(int'(pick_id), NUM_REQ));
          if (bus.req_lock[pick_id]) begin
            state_nx = LOCKED;
            owner_nx = pick_id;
            cnt_nx   = '0;
          end
        end
      end
    endcase
    if (!reset) begin
      ready  = '0;
      accept = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ARB;
      rr_ptr   <= '0;
      owner    <= '0;
      lock_cnt <= '0;
      wreg     <= '0;
      wdata    <= '0;
      wen      <= 1'b0;
      gid      <= '0;
    end else begin
      state    <= state_nx;
      rr_ptr   <= ptr_nx;
      owner    <= owner_nx;
      lock_cnt <= cnt_nx;
      wen      <= 1'b0;
      if (accept) begin
        wreg  <= reg_arr[acc_id];
        wdata <= data_arr[acc_id];
        gid   <= acc_id;
        wen   <= !((ZERO_REG_RO != 0) && (reg_arr[acc_id] == '0));
      end
    end
  end

  assign bus.req_ready  = ready;
  assign bus.write_reg  = wreg;
  assign bus.write_data = wdata;
  assign bus.reg_write  = wen;
  assign bus.grant_id   = gid;
  assign bus.locked     = (state == LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// Scoreboard bench: a queue-based reference model predicts handshakes and
// register-file writes; a separate monitor checks every write as it appears.
module tb_regfile_write_arbiter;
  import regfile_arb_pkg::*;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int LM = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  regfile_write_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM), .ZERO_REG_RO(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    int           due;
    int           id;
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit            m_valid [N];
  bit            m_lock  [N];
  logic [AW-1:0] m_reg   [N];
  logic [DW-1:0] m_data  [N];
  int m_ptr = 0, m_owner = -1, m_idle = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic apply();
    bus.req_valid = {m_valid[2], m_valid[1], m_valid[0]};
    bus.req_lock  = {m_lock[2], m_lock[1], m_lock[0]};
    bus.req_reg   = {m_reg[2], m_reg[1], m_reg[0]};
    bus.req_data  = {m_data[2], m_data[1], m_data[0]};
  endtask

  task automatic set_req(input int i, input bit v, input bit l, input int r, input logic [DW-1:0] d);
    m_valid[i] = v;
    m_lock[i]  = l;
    m_reg[i]   = AW'(r);
    m_data[i]  = d;
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 0, '0);
  endtask

  // One arbitration cycle: predict the winner, check handshake, update model
  task automatic tick();
    int w;
    logic [N-1:0] exp_ready;
    apply();
    @(negedge clk);
    w = -1;
    if (m_owner >= 0) begin
      if (m_valid[m_owner]) w = m_owner;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (w < 0 && m_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end
    end
    exp_ready = (w >= 0) ? N'(1 << w) : '0;
    chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    chk("locked", 64'(bus.locked), 64'(m_owner >= 0));
    if (w >= 0) begin
      if (m_reg[w] != '0) sbq.push_back('{cyc + 1, w, m_reg[w], m_data[w]});
      if (m_owner < 0) begin
        m_ptr = (w + 1) % N;
        if (m_lock[w]) begin
          m_owner = w;
          m_idle  = 0;
        end
      end else if (m_lock[w]) begin
        m_idle = 0;
      end else begin
        m_ptr   = (w + 1) % N;
        m_owner = -1;
      end
    end else if (m_owner >= 0) begin
      m_idle++;
      if (m_idle == LM) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_idle  = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_reg_write"},  64'(bus.reg_write), 64'd0);
    chk({tag, "_write_reg"},  64'(bus.write_reg), 64'd0);
    chk({tag, "_write_data"}, 64'(bus.write_data), 64'd0);
    chk({tag, "_grant_id"},   64'(bus.grant_id), 64'd0);
    chk({tag, "_locked"},     64'(bus.locked), 64'd0);
    chk({tag, "_req_ready"},  64'(bus.req_ready), 64'd0);
  endtask

  // Monitor: every write on the port must match the oldest prediction, on time
  initial begin
    forever begin
      @(negedge clk);
      while (sbq.size() > 0 && sbq[0].due < cyc) begin
        total++;
        bad++;
        $display("FAIL missing_write: got none expected reg %0d data %0h id %0d", sbq[0].r, sbq[0].d, sbq[0].id);
        void'(sbq.pop_front());
      end
      if (bus.reg_write === 1'b1) begin
        if (sbq.size() == 0 || sbq[0].due != cyc) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got reg %0d data %0h id %0d expected no write (cycle %0d)",
                   bus.write_reg, bus.write_data, bus.grant_id, cyc);
        end else begin
          chk("grant_id",   64'(bus.grant_id), 64'(sbq[0].id));
          chk("write_reg",  64'(bus.write_reg), 64'(sbq[0].r));
          chk("write_data", 64'(bus.write_data), 64'(sbq[0].d));
          void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_all();
    apply();
    #12;
    check_reset_outputs("por");
    @(posedge clk);
    #2 reset = 1'b1;

    // Round-robin with everyone valid
    set_req(0, 1, 0, 1, 32'hA0);
    set_req(1, 1, 0, 2, 32'hB0);
    set_req(2, 1, 0, 3, 32'hC0);
    repeat (6) tick();

    // Single write latency
    idle_all();
    tick();
    set_req(1, 1, 0, 5, 32'hDEADBEEF);
    tick();
    idle_all();
    repeat (2) tick();

    // Locked burst from requester 2 while 0 and 1 keep asking
    set_req(0, 1, 0, 7, 32'h70);
    set_req(1, 1, 0, 8, 32'h80);
    set_req(2, 1, 1, 9, 32'h90);
    tick();
    m_data[2] = 32'h91;
    tick();
    m_lock[2] = 1'b0;
    m_data[2] = 32'h92;
    tick();
    tick();

    // Lock timeout: requester 0 locks and goes quiet
    idle_all();
    tick();
    set_req(0, 1, 1, 4, 32'h40);
    tick();
    set_req(0, 0, 0, 4, 32'h40);
    set_req(1, 1, 0, 6, 32'h60);
    repeat (10) tick();

    // Register 0 writes complete the handshake but never reach the port
    idle_all();
    tick();
    set_req(0, 1, 0, 0, 32'h1234);
    tick();
    set_req(0, 1, 0, 10, 32'hA);
    set_req(1, 1, 0, 11, 32'hB);
    set_req(2, 1, 0, 12, 32'hC);
    tick();

    // Reset while a write is registered and requests are pending
    set_req(0, 1, 0, 1, 32'h11);
    set_req(1, 1, 0, 2, 32'h22);
    set_req(2, 1, 0, 3, 32'h33);
    tick();
    #2 reset = 1'b0;
    sbq.delete();
    m_ptr = 0;
    m_owner = -1;
    m_idle = 0;
    #1 check_reset_outputs("mid_reset");
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (3) tick();

    // Random traffic: busy phase, then sparse phase to provoke lock timeouts
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        set_req(i, (c < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                $urandom_range(0, 3) == 0, $urandom_range(0, 31), $urandom());
      end
      tick();
    end

    idle_all();
    repeat (3) tick();
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port (write_reg / write_data / reg_write) between NUM_REQ requesters, e.g. ALU writeback, shifter writeback and load unit.
- Round-robin arbitration with a per-requester valid/ready handshake.
- Optional locked bursts, so one requester can own the port for consecutive writes.
- The accepted write drives the register file one cycle after acceptance.

Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- ADDR_W, 5, register index width
- DATA_W, 32, write data width
- LOCK_MAX, 8, idle cycles of the lock owner before the lock is force-released
- ZERO_REG_RO, 1, when 1, writes to register 0 are accepted but never asserted on reg_write

Ports:
- clk, input, 1, clock; all state updates on rising edge
- reset, input, 1, asynchronous, active-low reset
- req_valid, input, NUM_REQ, request pending per requester
- req_ready, output, NUM_REQ, request accepted this cycle (one-hot or zero)
- req_lock, input, NUM_REQ, keep ownership after this transfer
- req_reg, input, NUM_REQ*ADDR_W, destination index per requester (requester i at bits [i*ADDR_W +: ADDR_W])
- req_data, input, NUM_REQ*DATA_W, write data per requester (same packing)
- write_reg, output, ADDR_W, register file write index
- write_data, output, DATA_W, register file write data
- reg_write, output, 1, register file write enable
- grant_id, output, clog2(NUM_REQ), requester whose write is on the port this cycle
- locked, output, 1, arbiter is in LOCKED state

Behaviour:
- Reset (reset=0, asynchronous):
  - write_reg=0, write_data=0, reg_write=0, grant_id=0, locked=0, req_ready=0.
  - rr_ptr=0, lock counter=0, state=ARB.
  - Any write registered but not yet issued is discarded.
- Acceptance: requester i is accepted when req_valid[i] & req_ready[i]. At most one accept per cycle. req_ready is combinational from req_valid and state.
- State ARB:
  - Winner is the first valid requester scanning from rr_ptr upward, wrapping modulo NUM_REQ.
  - req_ready[winner]=1; all other req_ready bits are 0.
  - On accept, rr_ptr <= (winner+1) mod NUM_REQ.
  - If req_lock[winner]=1 at accept: state <= LOCKED, owner <= winner, lock counter <= 0.
  - No valid requester: req_ready=0 and rr_ptr holds.
- State LOCKED:
  - Only the owner may be accepted: req_ready[owner]=req_valid[owner]; all others 0.
  - rr_ptr does not advance.
  - Accept with req_lock[owner]=0: state <= ARB, and rr_ptr <= owner+1.
  - Accept with req_lock[owner]=1: stay in LOCKED and clear the lock counter.
  - Owner not valid in a cycle: counter increments. When it reaches LOCK_MAX, state <= ARB next cycle and rr_ptr <= owner+1.
  - locked=1 throughout LOCKED.
- Output latency: exactly 1 cycle.
  - The cycle after an accept: reg_write=1, write_reg=req_reg, write_data=req_data and grant_id=id, all captured at accept.
  - Cycle after a non-accept: reg_write=0. write_reg, write_data and grant_id hold their last values.
- Register 0: if ZERO_REG_RO=1 and the accepted req_reg=0, the request is accepted (ready handshake completes and the round-robin/lock state updates normally) but reg_write stays 0 the next cycle.
- Back-to-back: one accept per cycle sustained. Full throughput with all requesters valid.
- Requester that drops valid without being accepted: no state change. The pointer is unaffected.
- Widths: grant_id = max(1, clog2(NUM_REQ)). All pointer arithmetic is modulo NUM_REQ, including non-power-of-2 values.

Decomposition:
- Package regfile_arb_pkg holds:
  - default NUM_REQ, ADDR_W, DATA_W, LOCK_MAX
  - state encoding: ARB=1'b0, LOCKED=1'b1
  - a clog2 function
- Sub-module rr_priority_picker: purely combinational rotating-priority encoder.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, winner index, any_valid.
  - Instantiated once; reusable by future read-port schedulers.

Test Plan:
- Reset mid-traffic: reset pulsed low while requests are pending and one write is registered.
  - Outputs are 0 immediately (asynchronous) and the registered write is never issued.
  - After release, requester 0 is granted first.
- Round-robin fairness: all 3 requesters valid for 6 cycles, writing regs 1/2/3 with data 32'hA0/B0/C0.
  - Grant order is 0,1,2,0,1,2.
  - reg_write=1 every cycle from cycle 2, with write_reg/write_data matching the granted requester.
- Single write latency: requester 1 writes reg 5 = 32'hDEADBEEF.
  - req_ready[1]=1 in cycle t.
  - In cycle t+1: reg_write=1, write_reg=5, write_data=32'hDEADBEEF, grant_id=1.
  - In cycle t+2: reg_write=0.
- Locked burst: requester 2 issues 3 writes with lock=1,1,0 while 0 and 1 are continuously valid.
  - Requester 2 gets 3 consecutive grants and locked=1 for those cycles.
  - Requester 0 is granted next.
- Lock timeout: requester 0 locks, then deasserts valid while requester 1 is valid.
  - req_ready[1] stays 0 for LOCK_MAX=8 cycles, then requester 1 is granted.
- Register 0 suppression: requester 0 writes reg 0 = 32'h1234.
  - Handshake completes and reg_write=0 the following cycle.
  - The next grant goes to requester 1.
